regfile_bypass: RTL and testbench
=================================

Name: regfile_bypass

Overview:
- General-purpose register file serving the decode stage's two read-request ports (read enable + address, data returned the same cycle) and the write-back stage's write port.
- 32 x 32-bit storage; register $0 is hardwired to zero.
- Write-through bypass: a write and a read of the same register in the same cycle returns the new value.
- A post-reset clear sweep and a req/ack debug read port provide sequential control.

Parameters:
- DATA_W, 32, register width
- ADDR_W, 5, register address width
- NREGS, 32, number of registers; must equal 2**ADDR_W

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- we  in  1  write enable from write-back
- waddr  in  ADDR_W  write address
- wdata  in  DATA_W  write data
- re1  in  1  read enable, port 1
- raddr1  in  ADDR_W  read address, port 1
- rdata1  out  DATA_W  read data, port 1 (combinational)
- re2  in  1  read enable, port 2
- raddr2  in  ADDR_W  read address, port 2
- rdata2  out  DATA_W  read data, port 2 (combinational)
- dbg_req  in  1  debug read request, level, held until ack
- dbg_addr  in  ADDR_W  debug read address, stable while dbg_req is high
- dbg_ack  out  1  one-cycle debug acknowledge
- dbg_data  out  DATA_W  debug read data, valid when dbg_ack=1, held until the next ack
- ready  out  1  high once the clear sweep has completed

Behaviour:
- Reset (edge with rst=1):
  - state<=INIT, clr_ptr<=0, ready<=0, dbg_ack<=0, dbg_data<=0.
  - Storage contents are don't-care until the sweep rewrites them.
  - While rst=1, rdata1/rdata2 = 0.
- FSM states: INIT, RUN.
- INIT:
  - Each edge writes 0 to entry clr_ptr, then clr_ptr++.
  - At the edge where clr_ptr==NREGS-1, that entry is written, state<=RUN and ready<=1.
  - ready therefore rises on the NREGS-th rising edge after rst deasserts.
  - we is ignored. dbg_req is not serviced; it stays pending and is served in RUN.
  - rdata1/rdata2 = 0.
- RUN write: at the edge with we=1 and waddr!=0, mem[waddr]<=wdata. A write to waddr=0 is discarded.
- Read port n in RUN, priority order:
  1. re_n=0 -> 0
  2. raddr_n=0 -> 0
  3. we=1 and waddr==raddr_n -> wdata (bypass)
  4. otherwise -> mem[raddr_n]
  - Both ports are independent and may hit the same address.
- Debug port (RUN only):
  - At an edge with dbg_req=1 and dbg_ack=0: dbg_ack<=1, and dbg_data<= the value port 1's rule would return with re=1 and addr=dbg_addr, bypass included.
  - The next edge forces dbg_ack<=0, so ack never stays high two consecutive cycles.
  - A held request is re-served every other cycle. The requester must drop dbg_req in the ack cycle.
- Simultaneous events: a write to register X and a debug read of X at the same edge returns the new data.
- Reset mid-operation:
  - Any edge with rst=1 aborts everything: pending debug is dropped, ready drops to 0 at that edge.
  - The full sweep restarts and all registers read 0 afterwards.
- Width: no arithmetic beyond clr_ptr. clr_ptr is ADDR_W bits and is not advanced after RUN is entered.

Test Plan:
- Reset sweep: hold rst 3 cycles, release -> ready=0 for edges 1..31, ready=1 after edge 32. During INIT, re1=1/raddr1=5 returns 0, and we=1/waddr=5/wdata=0xAAAA5555 leaves mem[5]=0.
- Basic R/W: in RUN, write 0x1234ABCD to r7; next cycle re1=1/raddr1=7 -> rdata1=0x1234ABCD. Same read with re1=0 -> rdata1=0.
- $0 and bypass:
  - Write 0xFFFFFFFF to r0, then read r0 -> 0.
  - Same cycle: we=1/waddr=9/wdata=0xDEADBEEF with re2=1/raddr2=9 -> rdata2=0xDEADBEEF before the edge.
  - Port 1 reading r9 in the same cycle also returns 0xDEADBEEF.
- Debug handshake:
  - r3=0x55 in RUN; assert dbg_req with dbg_addr=3 -> dbg_ack=1 for exactly one cycle, dbg_data=0x55.
  - Hold dbg_req high -> ack pattern 1,0,1,0.
  - Request issued during INIT -> acked on the first RUN edge, data 0.
- Debug with simultaneous write: dbg_req with dbg_addr=12 and we=1/waddr=12/wdata=0x77 at the same edge -> dbg_data=0x77.
- Reset mid-operation: write r4=0x99, assert rst for one cycle in the middle of a debug request -> no ack, ready=0. After 32 edges ready=1 and r4 reads 0.

Source files
------------

// File: rtl/regfile_bypass.sv
// regfile_bypass: 32x32 register file with write-through bypass, post-reset clear sweep and debug read port
module regfile_bypass #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREGS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_data,
  output logic              ready
);
  typedef enum logic {INIT, RUN} state_t;
  state_t state;
  logic [DATA_W-1:0] mem [NREGS];
  logic [ADDR_W-1:0] clr_ptr;
  logic run;
  logic [DATA_W-1:0] dbg_val;
  assign run = state == RUN && !rst;
  // reads return 0 outside RUN because storage is undefined until the sweep finishes
  assign rdata1  = (!run || !re1 || raddr1 == '0) ? '0 : (we && waddr == raddr1) ? wdata : mem[raddr1];
  assign rdata2  = (!run || !re2 || raddr2 == '0) ? '0 : (we && waddr == raddr2) ? wdata : mem[raddr2];
  assign dbg_val = (dbg_addr == '0) ? '0 : (we && waddr == dbg_addr) ? wdata : mem[dbg_addr];
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= INIT;
      clr_ptr  <= '0;
      ready    <= 1'b0;
      dbg_ack  <= 1'b0;
      dbg_data <= '0;
    end else if (state == INIT) begin
      mem[clr_ptr] <= '0;
      if (clr_ptr == ADDR_W'(NREGS - 1)) begin
        state <= RUN;
        ready <= 1'b1;
      end else begin
        clr_ptr <= clr_ptr + 1'b1;
      end
    end else begin
      if (we && waddr != '0) mem[waddr] <= wdata;
      dbg_ack <= dbg_req && !dbg_ack;
      if (dbg_req && !dbg_ack) dbg_data <= dbg_val;
    end
  end
endmodule

// File: tb/tb_regfile_bypass.sv
// tb_regfile_bypass: table-driven read/write vectors plus directed sweep, debug and reset sequences
module tb_regfile_bypass;
  logic clk = 0, rst = 1, we = 0, re1 = 0, re2 = 0, dbg_req = 0, dbg_ack, ready;
  logic [4:0] waddr = 0, raddr1 = 0, raddr2 = 0, dbg_addr = 0;
  logic [31:0] wdata = 0, rdata1, rdata2, dbg_data;
  int n_vec = 0, n_bad = 0;

  regfile_bypass dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
    .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_ack(dbg_ack), .dbg_data(dbg_data),
    .ready(ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic we; logic [4:0] waddr; logic [31:0] wdata;
    logic re1; logic [4:0] raddr1; logic re2; logic [4:0] raddr2;
    logic [31:0] exp1; logic [31:0] exp2;
  } vec_t;
  vec_t vecs [12];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    vecs[0]  = '{1, 7,  32'h1234ABCD, 0, 7,  0, 7,  32'h0,        32'h0};
    vecs[1]  = '{0, 0,  32'h0,        1, 7,  1, 7,  32'h1234ABCD, 32'h1234ABCD};
    vecs[2]  = '{0, 0,  32'h0,        0, 7,  1, 7,  32'h0,        32'h1234ABCD};
    vecs[3]  = '{1, 0,  32'hFFFFFFFF, 1, 0,  0, 0,  32'h0,        32'h0};
    vecs[4]  = '{0, 0,  32'h0,        1, 0,  1, 7,  32'h0,        32'h1234ABCD};
    vecs[5]  = '{1, 9,  32'hDEADBEEF, 1, 9,  1, 9,  32'hDEADBEEF, 32'hDEADBEEF};
    vecs[6]  = '{0, 0,  32'h0,        1, 9,  1, 8,  32'hDEADBEEF, 32'h0};
    vecs[7]  = '{1, 9,  32'h11,       1, 9,  1, 7,  32'h11,       32'h1234ABCD};
    vecs[8]  = '{1, 3,  32'h55,       1, 9,  1, 3,  32'h11,       32'h55};
    vecs[9]  = '{1, 31, 32'hCAFEF00D, 1, 31, 1, 30, 32'hCAFEF00D, 32'h0};
    vecs[10] = '{0, 0,  32'h0,        1, 31, 1, 3,  32'hCAFEF00D, 32'h55};
    vecs[11] = '{1, 4,  32'h99,       1, 4,  0, 4,  32'h99,       32'h0};

    // reset held three cycles
    re1 = 1; raddr1 = 5;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_ready", 32'(ready), 0);
      chk("rst_rdata1", rdata1, 0);
    end
    chk("rst_ack", 32'(dbg_ack), 0);
    chk("rst_dbg_data", dbg_data, 0);

    // sweep: write and debug request issued during INIT must be ignored / deferred
    rst = 0; we = 1; waddr = 5; wdata = 32'hAAAA5555; dbg_req = 1; dbg_addr = 5;
    for (int k = 1; k <= 32; k++) begin
      #1 if (k < 32) chk("init_rdata1", rdata1, 0);
      step();
      chk("init_ready", 32'(ready), 32'(k == 32));
      chk("init_ack", 32'(dbg_ack), 0);
    end
    we = 0;
    #1 chk("init_write_ignored", rdata1, 0);
    step();
    chk("init_dbg_ack", 32'(dbg_ack), 1);
    chk("init_dbg_data", dbg_data, 0);
    dbg_req = 0;

    foreach (vecs[i]) begin
      we = vecs[i].we; waddr = vecs[i].waddr; wdata = vecs[i].wdata;
      re1 = vecs[i].re1; raddr1 = vecs[i].raddr1; re2 = vecs[i].re2; raddr2 = vecs[i].raddr2;
      #1;
      chk($sformatf("vec%0d_rdata1", i), rdata1, vecs[i].exp1);
      chk($sformatf("vec%0d_rdata2", i), rdata2, vecs[i].exp2);
      step();
    end
    we = 0;

    // held debug request: ack alternates 1,0,1,0
    dbg_req = 1; dbg_addr = 3;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("dbg_held_ack", 32'(dbg_ack), 32'(k % 2 == 0));
      chk("dbg_held_data", dbg_data, 32'h55);
    end
    dbg_req = 0;
    step();
    chk("dbg_idle_ack", 32'(dbg_ack), 0);

    // debug read racing a write to the same register
    dbg_req = 1; dbg_addr = 12; we = 1; waddr = 12; wdata = 32'h77;
    step();
    chk("dbg_bypass_ack", 32'(dbg_ack), 1);
    chk("dbg_bypass_data", dbg_data, 32'h77);
    dbg_req = 0; we = 0; re1 = 1; raddr1 = 12;
    step();
    chk("dbg_bypass_drop", 32'(dbg_ack), 0);
    chk("dbg_data_held", dbg_data, 32'h77);
    chk("r12_written", rdata1, 32'h77);

    // reset in the middle of a debug request
    raddr1 = 4;
    #1 chk("r4_before_rst", rdata1, 32'h99);
    dbg_req = 1; dbg_addr = 4; rst = 1;
    #1 chk("rst_mid_rdata1", rdata1, 0);
    step();
    chk("rst_mid_ack", 32'(dbg_ack), 0);
    chk("rst_mid_ready", 32'(ready), 0);
    chk("rst_mid_dbg_data", dbg_data, 0);
    rst = 0; dbg_req = 0;
    for (int k = 1; k <= 32; k++) begin
      step();
      chk("resweep_ready", 32'(ready), 32'(k == 32));
      chk("resweep_ack", 32'(dbg_ack), 0);
    end
    #1 chk("r4_cleared", rdata1, 0);
    raddr1 = 7;
    #1 chk("r7_cleared", rdata1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
